// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential integer divider.
package div_seq_pkg;

  localparam int unsigned DIV_XLEN = 32;
  localparam int unsigned CNT_W    = $clog2(DIV_XLEN);

  typedef enum logic [1:0] {
    DIV_FUNC_DIV  = 2'b00,
    DIV_FUNC_DIVU = 2'b01,
    DIV_FUNC_REM  = 2'b10,
    DIV_FUNC_REMU = 2'b11
  } div_func_e;

  typedef enum logic [2:0] {
    DS_IDLE = 3'd0,
    DS_PREP = 3'd1,
    DS_ITER = 3'd2,
    DS_FIX  = 3'd3,
    DS_DONE = 3'd4
  } div_state_e;

  // Latched request: bit1 of func selects remainder, bit0 selects unsigned.
  typedef struct packed {
    logic [1:0]          func;
    logic [DIV_XLEN-1:0] opa;
    logic [DIV_XLEN-1:0] opb;
  } div_req_t;

  function automatic logic [DIV_XLEN-1:0] mag(input logic [DIV_XLEN-1:0] x, input logic sgn);
    return (sgn && x[DIV_XLEN-1]) ? DIV_XLEN'(-x) : x;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// EX <-> divider request/response bundle.
interface div_seq_if;
  import div_seq_pkg::*;

  logic                req_vld;
  logic [1:0]          req_func;
  logic [DIV_XLEN-1:0] req_opa;
  logic [DIV_XLEN-1:0] req_opb;
  logic                flush;
  logic                rsp_rdy;
  logic                busy;
  logic                rsp_vld;
  logic [DIV_XLEN-1:0] rsp_data;
  logic                stall;

  modport master (
    output req_vld, req_func, req_opa, req_opb, flush, rsp_rdy,
    input  busy, rsp_vld, rsp_data, stall
  );

  modport slave (
    input  req_vld, req_func, req_opa, req_opb, flush, rsp_rdy,
    output busy, rsp_vld, rsp_data, stall
  );

endinterface

// File: rtl/div_seq_iter.sv
// One restoring-division step; isolated so a higher-radix step can replace it.
module div_seq_iter
  import div_seq_pkg::*;
#(
  parameter int unsigned XLEN = DIV_XLEN
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] q_nxt
);

  logic [XLEN:0] p;
  logic          ge;

  // Remainder stays below the divisor, so the difference always fits in XLEN bits.
  always_comb begin
    p       = {rem, q[XLEN-1]};
    ge      = (p >= {1'b0, divisor});
    rem_nxt = ge ? XLEN'(p - {1'b0, divisor}) : XLEN'(p);
    q_nxt   = {q[XLEN-2:0], ge};
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer for EX; holds the result until EX advances.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned XLEN = DIV_XLEN
) (
  input logic      clk,
  input logic      rst,
  div_seq_if.slave bus
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e        state, state_n;
  logic              busy_d, vld_d;
  logic              busy_q, vld_q;

  div_req_t          req_q;
  logic [XLEN-1:0]   rem_q, q_q, dvsr_q, result_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q, neg_r, sup_fix;

  logic              accept, sgn, div0, ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN-1:0]   rem_nxt, q_nxt;
  logic [XLEN-1:0]   q_fix, r_fix, res_fix;

  assign accept = (state == DS_IDLE) && bus.req_vld && !bus.flush;

  // Operand classification, evaluated on the latched request during PREP.
  always_comb begin
    sgn   = !req_q.func[0];
    a_mag = mag(req_q.opa, sgn);
    b_mag = mag(req_q.opb, sgn);
    div0  = (req_q.opb == '0);
    ovf   = sgn && (req_q.opa == INT_MIN) && (req_q.opb == '1);
  end

  always_comb begin
    q_fix   = (neg_q && !sup_fix) ? XLEN'(-q_q) : q_q;
    r_fix   = (neg_r && !sup_fix) ? XLEN'(-rem_q) : rem_q;
    res_fix = req_q.func[1] ? r_fix : q_fix;
  end

  div_seq_iter #(.XLEN(XLEN)) u_iter (
    .rem     (rem_q),
    .q       (q_q),
    .divisor (dvsr_q),
    .rem_nxt (rem_nxt),
    .q_nxt   (q_nxt)
  );

  // State register and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DS_IDLE;
      busy_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      state  <= state_n;
      busy_q <= busy_d;
      vld_q  <= vld_d;
    end
  end

  // Next state; flush overrides every transition.
  always_comb begin
    state_n = state;
    if (bus.flush) begin
      state_n = DS_IDLE;
    end else begin
      case (state)
        DS_IDLE: if (bus.req_vld) state_n = DS_PREP;
        DS_PREP: state_n = (div0 || ovf) ? DS_FIX : DS_ITER;
        DS_ITER: if (cnt_q == '0) state_n = DS_FIX;
        DS_FIX:  state_n = DS_DONE;
        DS_DONE: if (bus.rsp_rdy) state_n = DS_IDLE;
        default: state_n = DS_IDLE;
      endcase
    end
  end

  // Status outputs are decoded from the upcoming state so they register alongside it.
  always_comb begin
    busy_d = 1'b0;
    vld_d  = 1'b0;
    case (state_n)
      DS_PREP, DS_ITER, DS_FIX: busy_d = 1'b1;
      DS_DONE:                  vld_d  = 1'b1;
      default:                  ;
    endcase
  end

  // Datapath: request latch, iteration registers, counter and sign flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      sup_fix <= 1'b0;
    end else begin
      case (state)
        DS_IDLE: begin
          if (accept) begin
            req_q <= '{func: bus.req_func, opa: bus.req_opa, opb: bus.req_opb};
          end
        end
        DS_PREP: begin
          neg_q   <= sgn && (req_q.opa[XLEN-1] ^ req_q.opb[XLEN-1]);
          neg_r   <= sgn && req_q.opa[XLEN-1];
          sup_fix <= div0 || ovf;
          dvsr_q  <= b_mag;
          if (div0) begin
            q_q   <= '1;
            rem_q <= req_q.opa;
          end else if (ovf) begin
            q_q   <= INT_MIN;
            rem_q <= '0;
          end else begin
            q_q   <= a_mag;
            rem_q <= '0;
            cnt_q <= CNT_W'(XLEN - 1);
          end
        end
        DS_ITER: begin
          rem_q <= rem_nxt;
          q_q   <= q_nxt;
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result register: loaded in FIX, cleared whenever the sequencer heads back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else if (state_n == DS_IDLE) begin
      result_q <= '0;
    end else if (state == DS_FIX) begin
      result_q <= res_fix;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rsp_vld  = vld_q;
  assign bus.rsp_data = result_q;
  assign bus.stall    = bus.req_vld && !vld_q && !rst;

endmodule

// File: tb/tb_div_seq.sv
// Randomized bench for div_seq against a transaction-level reference model.
module tb_div_seq;
  import div_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_seq_if bus ();

  div_seq #(.XLEN(DIV_XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Model state: one outstanding operation, its acceptance cycle, latency and result.
  bit          pending = 1'b0;
  int          acc     = 0;
  int          lat     = 0;
  logic [31:0] res     = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit is_ovf(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    return !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] q, r;
    if (b == '0) begin
      q = '1; r = a;
    end else if (is_ovf(f, a, b)) begin
      q = 32'h8000_0000; r = '0;
    end else if (!f[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return f[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    return (b == '0 || is_ovf(f, a, b)) ? 3 : 35;
  endfunction

  // Per-cycle compare of every output against the model, then advance the model.
  always @(negedge clk) begin : cmp
    logic        ev;
    logic [31:0] ed;
    if (chk_en) begin
      ev = pending && (cyc >= acc + lat);
      ed = ev ? res : '0;
      chk("rsp_vld",  32'(bus.rsp_vld), 32'(ev));
      chk("busy",     32'(bus.busy), 32'(pending && !ev));
      chk("stall",    32'(bus.stall), 32'(bus.req_vld && !ev && !rst));
      chk("rsp_data", bus.rsp_data, ed);
      if (rst || (pending && bus.flush)) begin
        pending = 1'b0;
      end else if (pending) begin
        if (ev && bus.rsp_rdy) pending = 1'b0;
      end else if (bus.req_vld && !bus.flush) begin
        pending = 1'b1;
        acc     = cyc;
        res     = ref_div(bus.req_func, bus.req_opa, bus.req_opb);
        lat     = ref_lat(bus.req_func, bus.req_opa, bus.req_opb);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.req_vld  = 1'b1;
    bus.req_func = f;
    bus.req_opa  = a;
    bus.req_opb  = b;
  endtask

  // Waits (bounded) for rsp_vld; returns the cycle it was first seen or -1.
  task automatic wait_vld(output int seen);
    seen = -1;
    for (int i = 0; i < 60 && seen < 0; i++) begin
      @(negedge clk);
      if (bus.rsp_vld) seen = cyc;
    end
  endtask

  task automatic abort_op();
    step();
    bus.req_vld = 1'b0;
    bus.flush   = 1'b1;
    step();
    bus.flush   = 1'b0;
  endtask

  // One request; exp_lat < 0 leaves all checking to the per-cycle compare.
  task automatic do_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input logic [31:0] exp_d, input int exp_lat,
                       input string name);
    int t0, seen, vcnt;
    logic [31:0] d0;
    step();
    issue(f, a, b);
    t0 = cyc;
    wait_vld(seen);
    if (seen < 0) begin
      chk({name, " timeout"}, 32'd0, 32'd1);
      abort_op();
      return;
    end
    if (exp_lat >= 0) begin
      chk({name, " latency"}, 32'(seen - t0), 32'(exp_lat));
      chk({name, " data"}, bus.rsp_data, exp_d);
    end
    d0   = bus.rsp_data;
    vcnt = 1;
    for (int i = 1; i <= hold; i++) begin
      step();
      if (i == hold) bus.rsp_rdy = 1'b1;
      @(negedge clk);
      if (bus.rsp_vld) vcnt++;
      chk({name, " hold data"}, bus.rsp_data, d0);
      chk({name, " hold stall"}, 32'(bus.stall), 32'd0);
    end
    step();
    bus.rsp_rdy = 1'b0;
    bus.req_vld = 1'b0;
    @(negedge clk);
    chk({name, " vld cycles"}, 32'(vcnt), 32'(hold + 1));
    chk({name, " vld drop"}, 32'(bus.rsp_vld), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int t0, seen, vseen, k;
    logic [1:0]  f;
    logic [31:0] a, b;

    rst          = 1'b1;
    bus.req_vld  = 1'b0;
    bus.req_func = '0;
    bus.req_opa  = '0;
    bus.req_opb  = '0;
    bus.flush    = 1'b0;
    bus.rsp_rdy  = 1'b0;
    step();
    step();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset rsp_vld", 32'(bus.rsp_vld), 32'd0);
    chk("reset rsp_data", bus.rsp_data, 32'd0);
    step();
    rst = 1'b0;

    // Hand-computed values pinning the reference model.
    chk("pin divu", ref_div(DIV_FUNC_DIVU, 32'd100, 32'd7), 32'd14);
    chk("pin remu", ref_div(DIV_FUNC_REMU, 32'd100, 32'd7), 32'd2);
    chk("pin div neg", ref_div(DIV_FUNC_DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("pin rem neg", ref_div(DIV_FUNC_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("pin div0", ref_div(DIV_FUNC_DIV, 32'd5, 32'd0), 32'hFFFF_FFFF);
    chk("pin ovf", ref_div(DIV_FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    chk("pin lat ovf", 32'(ref_lat(DIV_FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF)), 32'd3);
    chk("pin lat divu", 32'(ref_lat(DIV_FUNC_DIVU, 32'h8000_0000, 32'hFFFF_FFFF)), 32'd35);

    do_op(DIV_FUNC_DIVU, 32'd100, 32'd7, 3, 32'd14, 35, "divu 100/7");
    do_op(DIV_FUNC_REMU, 32'd100, 32'd7, 1, 32'd2, 35, "remu 100/7");
    do_op(DIV_FUNC_DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, 35, "div -7/2");
    do_op(DIV_FUNC_REM, 32'hFFFF_FFF9, 32'd2, 2, 32'hFFFF_FFFF, 35, "rem -7/2");
    do_op(DIV_FUNC_REMU, 32'hFFFF_FFFF, 32'h10, 1, 32'hF, 35, "remu ff/10");
    do_op(DIV_FUNC_DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 3, "divu 5/0");
    do_op(DIV_FUNC_REM, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFB, 3, "rem -5/0");
    do_op(DIV_FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 3, "div ovf");
    do_op(DIV_FUNC_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 3, "rem ovf");

    // Flush at relative cycle 10, then a fresh request right behind it.
    step();
    issue(DIV_FUNC_DIVU, 32'd1000, 32'd3);
    t0    = cyc;
    vseen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_vld) vseen = 1;
      step();
    end
    bus.flush   = 1'b1;
    bus.req_vld = 1'b0;
    @(negedge clk);
    if (bus.rsp_vld) vseen = 1;
    step();
    bus.flush = 1'b0;
    issue(DIV_FUNC_DIVU, 32'd9, 32'd3);
    @(negedge clk);
    chk("flush no vld", 32'(vseen), 32'd0);
    chk("flush busy", 32'(bus.busy), 32'd0);
    chk("flush accept cycle", 32'(cyc - t0), 32'd11);
    wait_vld(seen);
    chk("post-flush vld cycle", 32'(seen - t0), 32'd46);
    chk("post-flush data", bus.rsp_data, 32'd3);
    step();
    bus.rsp_rdy = 1'b1;
    step();
    bus.rsp_rdy = 1'b0;
    bus.req_vld = 1'b0;

    // Reset in the middle of an operation.
    step();
    issue(DIV_FUNC_DIVU, 32'hFFFF_FFFF, 32'd3);
    repeat (20) step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst stall", 32'(bus.stall), 32'd0);
    step();
    rst         = 1'b0;
    bus.req_vld = 1'b0;
    @(negedge clk);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst rsp_vld", 32'(bus.rsp_vld), 32'd0);
    chk("rst rsp_data", bus.rsp_data, 32'd0);

    // Random traffic, occasionally flushed mid-flight.
    for (int n = 0; n < 40; n++) begin
      f = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(1, 40);
        step();
        issue(f, a, b);
        repeat (k) step();
        bus.flush   = 1'b1;
        bus.req_vld = 1'b0;
        step();
        bus.flush = 1'b0;
      end else begin
        do_op(f, a, b, $urandom_range(1, 3), '0, -1, "rand");
      end
      repeat ($urandom_range(0, 2)) step();
    end

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
